mem_arbiter: RTL

- Shares one single-port synchronous memory between two requesters.
  - Port 0: the core load/store/fetch path.
  - Port 1: a secondary master, e.g. video/DMA.
- Memory side matches the core memory contract:
  - byte address, 32-bit word;
  - write on clock edge when mem_we=1;
  - read data valid on the cycle after address issue.
- Policy: fixed priority to port 0, with an anti-starvation promotion for port 1.
- At most one grant per cycle. Read responses are returned to the issuing port.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_prio.sv | 38 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Holds the data word type, the port identifier enum and the strobe width.
package mem_arb_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_AUX  = 1'b1
    } port_id_t;

    localparam int STRB_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant logic for the memory arbiter: fixed priority to port 0 with an
// anti-starvation promotion of port 1 after MAX_WAIT waiting cycles.
// Ports: clk, rst (async, active-low), req0_valid, req1_valid in;
//        gnt0, gnt1 out (combinational, at most one high).
import mem_arb_pkg::*;

module mem_arb_prio #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    always_comb begin
        gnt1 = req1_valid && (!req0_valid || wait_cnt >= LIMIT);
        gnt0 = req0_valid && !gnt1;
    end

    // Counts cycles port 1 is left waiting; saturates rather than wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!req1_valid || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between a core port (0) and an
// auxiliary port (1); read data is routed back to the issuing port.
// Ports: clk, rst (async, active-low); per port reqN_valid/ready/addr/
//        wdata/we and rspN_valid/rdata; memory mem_addr/wdata/we/rdata.
// Optional MEM_ARB_STRB_EN adds req0_strb, req1_strb and mem_strb.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  word_t             req0_wdata,
    input  logic              req0_we,
`ifdef MEM_ARB_STRB_EN
    input  logic [STRB_W-1:0] req0_strb,
`endif
    output logic              rsp0_valid,
    output word_t             rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  word_t             req1_wdata,
    input  logic              req1_we,
`ifdef MEM_ARB_STRB_EN
    input  logic [STRB_W-1:0] req1_strb,
`endif
    output logic              rsp1_valid,
    output word_t             rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output word_t             mem_wdata,
    output logic              mem_we,
`ifdef MEM_ARB_STRB_EN
    output logic [STRB_W-1:0] mem_strb,
`endif
    input  word_t             mem_rdata
);

    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] last_addr;
    logic              rd_pend;
    port_id_t          rd_tag;

    mem_arb_prio #(
        .MAX_WAIT(MAX_WAIT)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .gnt0      (gnt0),
        .gnt1      (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Idle cycles keep the address bus on the last granted address.
    always_comb begin
        mem_addr  = last_addr;
        mem_wdata = req0_wdata;
        if (gnt1) begin
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end else if (gnt0) begin
            mem_addr  = req0_addr;
        end
        mem_we = rst && ((gnt0 && req0_we) || (gnt1 && req1_we));
    end

`ifdef MEM_ARB_STRB_EN
    always_comb begin
        mem_strb = '0;
        if (rst && gnt1) begin
            mem_strb = req1_strb;
        end else if (rst && gnt0) begin
            mem_strb = req0_strb;
        end
    end
`endif

    // One-deep read tag: memory data arrives the cycle after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr <= '0;
            rd_pend   <= 1'b0;
            rd_tag    <= PORT_CORE;
        end else begin
            if (gnt0 || gnt1) begin
                last_addr <= mem_addr;
            end
            rd_pend <= (gnt0 && !req0_we) || (gnt1 && !req1_we);
            rd_tag  <= gnt1 ? PORT_AUX : PORT_CORE;
        end
    end

    assign rsp0_valid = rd_pend && (rd_tag == PORT_CORE);
    assign rsp1_valid = rd_pend && (rd_tag == PORT_AUX);
    assign rsp0_rdata = mem_rdata;
    assign rsp1_rdata = mem_rdata;

endmodule
